saradc_cdac_seq: RTL and testbench
==================================

// Module: saradc_cdac_seq
// PURPOSE
// Synchronous switch sequencer for a parametrised binary-weighted SAR CDAC array.
// - Sample phase, then hold, then one MSB-first successive-approximation trial per bit.
// - Drives complementary CPRE/CHOLD/CRH/CRL switch pairs with break-before-make gaps.
// - Handshakes with the comparator and returns the conversion code.
// - Sits between the digital front end and the LSB/MSB CDAC arrays.
// PARAMETERS
// NBITS    8   resolution; width of CRH/CRL/DOUT
// NSAMP    2   sample-phase length in cycles (>=1)
// NSETTLE  1   DAC settle cycles after CRH[i] rises, before CMP_EN (>=1)
// TIMEOUT  15  max WAIT cycles for COMP_VALID before forced reject (>=1)
// PORTS
// CLK         in   1      clock; all state changes on rising edge
// RST         in   1      synchronous, active-high reset
// START       in   1      conversion request; sampled in IDLE only
// COMP        in   1      comparator decision; 1 = keep trial bit
// COMP_VALID  in   1      COMP qualifier; 1-cycle pulse
// CMP_EN      out  1      comparator strobe; 1-cycle pulse per bit
// CPRE,CPREB  out  1      sample switch pair (CPREB = ~CPRE always)
// CHOLD,CHOLDB out 1      hold switch pair (CHOLDB = ~CHOLD always)
// CRH,CRHB    out  NBITS  per-bit high-ref switches (CRHB = ~CRH always)
// CRL,CRLB    out  NBITS  per-bit low-ref switches (CRLB = ~CRL always)
// DOUT        out  NBITS  last result; held until next DONE
// DONE        out  1      1-cycle pulse when DOUT is updated
// BUSY        out  1      high in every state except IDLE
// ERR         out  1      sticky comparator-timeout flag; cleared by accepted START
// BEHAVIOUR
// - All outputs registered; each *B output comes from the same flop, inverted.
// - Reset values: CPRE=0, CHOLD=0, CRH=0, CRL=all 1s, CMP_EN=0, DOUT=0, DONE=0, BUSY=0, ERR=0.
// - RST mid-conversion: return to IDLE with reset values at the next edge; no DONE.
// - Per bit, CRH[i] and CRL[i] are never both 1 in any cycle.
// - CPRE and CHOLD are never both 1 in any cycle.
// - FSM: IDLE, SAMPLE, GAP, SET, SETTLE, COMPARE, WAIT, REJECT, FIN.
//   - IDLE: START=1 -> SAMPLE; CPRE<=1; ERR<=0; bit index i<=NBITS-1.
//   - START while not IDLE is ignored.
//   - SAMPLE: NSAMP cycles with CPRE=1, then -> GAP with CPRE<=0.
//   - GAP: 1 cycle with both CPRE and CHOLD low, then CHOLD<=1 -> SET.
//   - SET: 1 cycle with CRL[i]=0, then CRH[i]<=1 -> SETTLE.
//   - SETTLE: NSETTLE cycles, then -> COMPARE.
//   - COMPARE: CMP_EN=1 for one cycle -> WAIT.
//   - WAIT: on COMP_VALID, DOUT_shadow[i]<=COMP.
//     - COMP=1: keep CRH[i]=1, go to the next bit.
//     - COMP=0: CRH[i]<=0 -> REJECT.
//     - TIMEOUT cycles with no COMP_VALID: treat as COMP=0 and set ERR.
//     - COMP_VALID outside WAIT is ignored.
//   - REJECT: 1 cycle with CRH[i]=CRL[i]=0; CRL[i]<=1 on exit; go to the next bit.
//   - Next bit: if i>0, i<=i-1 -> SET; if i==0 -> FIN.
//   - FIN: DOUT<=shadow, DONE=1, CHOLD<=0, CRH<=0 -> IDLE; CRL<=all 1s on IDLE entry.
//   - BUSY falls in the cycle after FIN.
// - Timing, counted from the START-sampling edge with COMP_VALID in the first WAIT cycle:
//   DONE is high in cycle NSAMP+1+NBITS*(NSETTLE+3)+R+1, where R = number of rejected bits.
// - Counters: bit index uses $clog2(NBITS) bits; phase counter is sized to max(NSAMP,NSETTLE,TIMEOUT).
// TESTING
// - Reset: RST high 3 cycles -> CRL=all 1s, CRLB=0, CPREB=CHOLDB=1, BUSY=0, DOUT=0.
// - NBITS=4, NSAMP=2, NSETTLE=1; START at cycle 0; COMP sequence 1,0,1,1 (valid 1 cycle after CMP_EN)
//   -> DOUT=4'b1011, DONE high exactly in cycle 21, one CMP_EN per bit.
// - Switch checker every cycle over random COMP: CPRE&CHOLD==0, CRH&CRL==0, each *B == ~signal.
// - COMP_VALID withheld on bit 2, TIMEOUT=15 -> bit forced 0, ERR=1 after 15 WAIT cycles;
//   next START clears ERR.
// - START pulsed during SETTLE and during WAIT -> ignored, DOUT/DONE timing unchanged;
//   COMP_VALID in SETTLE -> ignored.
// - RST asserted in WAIT of bit 1 -> next cycle: reset values, BUSY=0, no DONE;
//   new START converts correctly.

Source files
------------

// File: rtl/saradc_cdac_seq.sv
// ============================================================================
// Module      : saradc_cdac_seq
// Description : Switch sequencer for a binary-weighted SAR CDAC: sample, hold,
//               then one MSB-first trial per bit with break-before-make gaps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module saradc_cdac_seq #(
    parameter int NBITS   = 8,
    parameter int NSAMP   = 2,
    parameter int NSETTLE = 1,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             COMP,
    input  logic             COMP_VALID,
    output logic             CMP_EN,
    output logic             CPRE,
    output logic             CPREB,
    output logic             CHOLD,
    output logic             CHOLDB,
    output logic [NBITS-1:0] CRH,
    output logic [NBITS-1:0] CRHB,
    output logic [NBITS-1:0] CRL,
    output logic [NBITS-1:0] CRLB,
    output logic [NBITS-1:0] DOUT,
    output logic             DONE,
    output logic             BUSY,
    output logic             ERR
);

    localparam int c_CNT_MAX0 = (NSAMP > NSETTLE) ? NSAMP : NSETTLE;
    localparam int c_CNT_MAX  = (c_CNT_MAX0 > TIMEOUT) ? c_CNT_MAX0 : TIMEOUT;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W    = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [c_CNT_W-1:0] c_SAMP_LAST   = c_CNT_W'(NSAMP - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(NSETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST     = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_TOP     = c_IDX_W'(NBITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ZERO    = '0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SAMPLE  = 4'd1,
        S_GAP     = 4'd2,
        S_SET     = 4'd3,
        S_SETTLE  = 4'd4,
        S_COMPARE = 4'd5,
        S_WAIT    = 4'd6,
        S_REJECT  = 4'd7,
        S_FIN     = 4'd8
    } t_state;

    t_state              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [NBITS-1:0]    r_shadow;
    logic                r_cmp_en;
    logic                r_cpre;
    logic                r_chold;
    logic [NBITS-1:0]    r_crh;
    logic [NBITS-1:0]    r_crl;
    logic [NBITS-1:0]    r_dout;
    logic                r_done;
    logic                r_busy;
    logic                r_err;

    logic [c_IDX_W-1:0]  w_idx_dn;
    logic                w_accept;
    logic [NBITS-1:0]    w_shadow_fin;

    assign w_idx_dn = r_idx - 1'b1;
    assign w_accept = (r_state == S_WAIT) && COMP_VALID && COMP;
    // FIN is only entered while on bit 0, so the live decision lands in bit 0
    assign w_shadow_fin = r_shadow | NBITS'(w_accept);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= c_IDX_TOP;
            r_shadow <= '0;
            r_cmp_en <= 1'b0;
            r_cpre   <= 1'b0;
            r_chold  <= 1'b0;
            r_crh    <= '0;
            r_crl    <= '1;
            r_dout   <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_cmp_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state  <= S_SAMPLE;
                        r_cpre   <= 1'b1;
                        r_err    <= 1'b0;
                        r_idx    <= c_IDX_TOP;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (r_cnt == c_SAMP_LAST) begin
                        r_cpre  <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_chold      <= 1'b1;
                    r_crl[r_idx] <= 1'b0;
                    r_state      <= S_SET;
                end
                S_SET: begin
                    // CRL[i] has been low for a full cycle; safe to close CRH[i]
                    r_crh[r_idx] <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cmp_en <= 1'b1;
                        r_state  <= S_COMPARE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMPARE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (COMP_VALID && COMP) begin
                        r_shadow[r_idx] <= 1'b1;
                        if (r_idx == c_IDX_ZERO) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_dout  <= w_shadow_fin;
                            r_chold <= 1'b0;
                            r_crh   <= '0;
                        end else begin
                            r_idx           <= w_idx_dn;
                            r_crl[w_idx_dn] <= 1'b0;
                            r_state         <= S_SET;
                        end
                    end else if (COMP_VALID || (r_cnt == c_TO_LAST)) begin
                        // explicit reject or comparator timeout
                        r_shadow[r_idx] <= 1'b0;
                        r_crh[r_idx]    <= 1'b0;
                        r_state         <= S_REJECT;
                        if (!COMP_VALID) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REJECT: begin
                    r_crl[r_idx] <= 1'b1;
                    if (r_idx == c_IDX_ZERO) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_dout  <= w_shadow_fin;
                        r_chold <= 1'b0;
                        r_crh   <= '0;
                    end else begin
                        r_idx           <= w_idx_dn;
                        r_crl[w_idx_dn] <= 1'b0;
                        r_state         <= S_SET;
                    end
                end
                S_FIN: begin
                    // CRH opened on FIN entry, so CRL can close now
                    r_crl   <= '1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cpre  <= 1'b0;
                    r_chold <= 1'b0;
                    r_crh   <= '0;
                    r_crl   <= '1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign CMP_EN = r_cmp_en;
    assign CPRE   = r_cpre;
    assign CPREB  = ~r_cpre;
    assign CHOLD  = r_chold;
    assign CHOLDB = ~r_chold;
    assign CRH    = r_crh;
    assign CRHB   = ~r_crh;
    assign CRL    = r_crl;
    assign CRLB   = ~r_crl;
    assign DOUT   = r_dout;
    assign DONE   = r_done;
    assign BUSY   = r_busy;
    assign ERR    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_saradc_cdac_seq.sv
// ============================================================================
// Module      : tb_saradc_cdac_seq
// Description : Directed-vector self-checking bench for saradc_cdac_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_saradc_cdac_seq;

    localparam int NBITS = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic             COMP;
    logic             COMP_VALID;
    logic             CMP_EN;
    logic             CPRE, CPREB, CHOLD, CHOLDB;
    logic [NBITS-1:0] CRH, CRHB, CRL, CRLB, DOUT;
    logic             DONE, BUSY, ERR;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    saradc_cdac_seq #(
        .NBITS  (NBITS),
        .NSAMP  (2),
        .NSETTLE(1),
        .TIMEOUT(15)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .COMP      (COMP),
        .COMP_VALID(COMP_VALID),
        .CMP_EN    (CMP_EN),
        .CPRE      (CPRE),
        .CPREB     (CPREB),
        .CHOLD     (CHOLD),
        .CHOLDB    (CHOLDB),
        .CRH       (CRH),
        .CRHB      (CRHB),
        .CRL       (CRL),
        .CRLB      (CRLB),
        .DOUT      (DOUT),
        .DONE      (DONE),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // switch-safety invariants sampled on the inactive edge
    always @(negedge CLK) begin
        if (mon_en) begin
            check("switch_inv",
                  32'({(CPRE & CHOLD), |(CRH & CRL), (CPREB !== ~CPRE),
                       (CHOLDB !== ~CHOLD), (CRHB !== ~CRH), (CRLB !== ~CRL)}),
                  32'd0);
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, ":crl"},    32'(CRL),    32'hF);
        check({tag, ":crlb"},   32'(CRLB),   32'h0);
        check({tag, ":crh"},    32'(CRH),    32'h0);
        check({tag, ":cpreb"},  32'(CPREB),  32'd1);
        check({tag, ":choldb"}, 32'(CHOLDB), 32'd1);
        check({tag, ":busy"},   32'(BUSY),   32'd0);
        check({tag, ":dout"},   32'(DOUT),   32'h0);
        check({tag, ":done"},   32'(DONE),   32'd0);
        check({tag, ":cmp_en"}, 32'(CMP_EN), 32'd0);
        check({tag, ":err"},    32'(ERR),    32'd0);
    endtask

    // One conversion. Cycle 1 is the cycle after the START-sampling edge.
    // COMP_VALID is returned in the cycle after each CMP_EN unless withheld.
    task automatic convert(input string tag, input logic [3:0] pattern,
                           input logic [3:0] withhold, input bit glitch,
                           input int abort_cyc, input int exp_done, input int exp_err_cyc);
        int cyc, b, pend_cyc, pend_bit, done_cyc, ncmp, err_cyc;
        logic [3:0] dout_seen;
        b = 3; pend_cyc = -1; pend_bit = 0; done_cyc = -1; ncmp = 0; err_cyc = 0;
        dout_seen = '0;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        cyc = 1;
        check({tag, ":busy_c1"}, 32'(BUSY), 32'd1);
        check({tag, ":err_c1"},  32'(ERR),  32'd0);
        while (1) begin
            if (CMP_EN) begin
                ncmp++;
                pend_cyc = cyc + 1;
                pend_bit = b;
                b--;
            end
            if (ERR && err_cyc == 0) err_cyc = cyc;
            if (DONE && done_cyc < 0) begin
                done_cyc  = cyc;
                dout_seen = DOUT;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            if (cyc >= 200) break;
            COMP_VALID = 1'b0;
            COMP       = 1'b0;
            START      = 1'b0;
            if (cyc == pend_cyc && pend_bit >= 0) begin
                COMP_VALID = !withhold[pend_bit];
                COMP       = pattern[pend_bit];
            end
            if (glitch && cyc == 9) begin
                COMP_VALID = 1'b1;
                COMP       = 1'b1;
            end
            if (glitch && (cyc == 5 || cyc == 11)) START = 1'b1;
            if (cyc == abort_cyc) RST = 1'b1;
            @(posedge CLK);
            #1;
            cyc++;
            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                RST = 1'b0;
                COMP_VALID = 1'b0;
                COMP = 1'b0;
                check({tag, ":no_done_before_abort"}, 32'(done_cyc < 0), 32'd1);
                reset_checks({tag, ":post_rst"});
                return;
            end
        end
        COMP_VALID = 1'b0;
        COMP       = 1'b0;
        START      = 1'b0;
        check({tag, ":done_cycle"}, 32'(done_cyc),  32'(exp_done));
        check({tag, ":dout"},       32'(dout_seen), 32'(pattern & ~withhold));
        check({tag, ":cmp_en_cnt"}, 32'(ncmp),      32'd4);
        check({tag, ":err_cycle"},  32'(err_cyc),   32'(exp_err_cyc));
        check({tag, ":err_final"},  32'(ERR),       32'(withhold != 4'b0));
        check({tag, ":busy_after"}, 32'(BUSY),      32'd0);
        check({tag, ":done_pulse"}, 32'(DONE),      32'd0);
        check({tag, ":crl_after"},  32'(CRL),       32'hF);
        check({tag, ":crh_after"},  32'(CRH),       32'h0);
        check({tag, ":dout_held"},  32'(DOUT),      32'(pattern & ~withhold));
    endtask

    initial begin
        logic [3:0] pat;
        RST = 1'b1; START = 1'b0; COMP = 1'b0; COMP_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        reset_checks("reset");
        RST = 1'b0;
        mon_en = 1'b1;

        convert("v1011", 4'b1011, 4'b0000, 1'b0, 0, 21, 0);
        convert("v1111", 4'b1111, 4'b0000, 1'b0, 0, 20, 0);
        convert("v0000", 4'b0000, 4'b0000, 1'b0, 0, 24, 0);
        // bit 2 timeout: WAIT spans cycles 11..25, ERR visible in cycle 26
        convert("tmo", 4'b1111, 4'b0100, 1'b0, 0, 35, 26);
        repeat (3) @(posedge CLK);
        #1;
        check("err_sticky_idle", 32'(ERR), 32'd1);
        convert("glitch", 4'b1010, 4'b0000, 1'b1, 0, 22, 0);
        convert("abort", 4'b1100, 4'b0000, 1'b0, 15, 0, 0);
        convert("post", 4'b0101, 4'b0000, 1'b0, 0, 22, 0);
        for (int k = 0; k < 3; k++) begin
            pat = 4'($urandom_range(0, 15));
            convert("rand", pat, 4'b0000, 1'b0, 0, 20 + (4 - $countones(pat)), 0);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
